trivium_ctrl: RTL and testbench

Sequencing controller that drives the Trivium `cipher_engine` from the host side. It accepts a key and IV as 32-bit words and loads them through the engine's load strobes, then runs the 1152-cycle warm-up. After that it serializes 32-bit plaintext words into the engine's bit input and reassembles the engine's bit output into 32-bit ciphertext words. Because Trivium is symmetric, the same block performs decryption when fed ciphertext.

---
 rtl/trivium_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_trivium_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_ctrl.sv
// Host-side sequencer for a Trivium cipher engine: key/IV loading, warm-up, word (de)serialisation.
// Optional build macro TRIVIUM_CTRL_MSB_FIRST_EN selects MSB-first bit serialisation.
module trivium_ctrl #(
  parameter int WARM_CYCLES = 1152
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        kiv_vld_i,
  output logic        kiv_rdy_o,
  input  logic [31:0] kiv_dat_i,
  input  logic        rekey_i,
  input  logic        pt_vld_i,
  output logic        pt_rdy_o,
  input  logic [31:0] pt_dat_i,
  output logic        ct_vld_o,
  input  logic        ct_rdy_i,
  output logic [31:0] ct_dat_o,
  output logic        keyed_o,
  output logic        eng_n_rst_o,
  output logic        eng_ce_o,
  output logic [31:0] eng_ld_dat_o,
  output logic [2:0]  eng_ld_a_o,
  output logic [2:0]  eng_ld_b_o,
  output logic        eng_dat_o,
  input  logic        eng_dat_i
);

  localparam logic [2:0] ST_CLR  = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_WARM = 3'd2;
  localparam logic [2:0] ST_IDLE = 3'd3;
  localparam logic [2:0] ST_RUN  = 3'd4;
  localparam logic [2:0] ST_HOLD = 3'd5;

  localparam logic [10:0] WARM_LAST = 11'(WARM_CYCLES - 1);

  logic [2:0]  state_r;
  logic [2:0]  state_nx_s;
  logic [2:0]  idx_r;
  logic [10:0] warm_cnt_r;
  logic [4:0]  bit_cnt_r;
  logic [31:0] pt_sr_r;
  logic [31:0] ct_sr_r;
  logic        tx_bit_s;

`ifdef TRIVIUM_CTRL_MSB_FIRST_EN
  assign tx_bit_s = pt_sr_r[31];
`else
  assign tx_bit_s = pt_sr_r[0];
`endif

  assign ct_dat_o = ct_sr_r;

  // Next-state decode and per-state handshake/engine control outputs.
  always_comb begin
    state_nx_s   = state_r;
    kiv_rdy_o    = 1'b0;
    pt_rdy_o     = 1'b0;
    ct_vld_o     = 1'b0;
    keyed_o      = 1'b0;
    eng_n_rst_o  = 1'b1;
    eng_ce_o     = 1'b0;
    eng_ld_dat_o = 32'h0000_0000;
    eng_ld_a_o   = 3'b000;
    eng_ld_b_o   = 3'b000;
    eng_dat_o    = 1'b0;
    case (state_r)
      ST_CLR: begin
        eng_n_rst_o = 1'b0;
        state_nx_s  = ST_LOAD;
      end
      ST_LOAD: begin
        kiv_rdy_o = 1'b1;
        if (kiv_vld_i) begin
          eng_ld_dat_o = kiv_dat_i;
          eng_ce_o     = 1'b1;
          if (idx_r < 3'd3) begin
            eng_ld_a_o = 3'b001 << idx_r;
          end else begin
            eng_ld_b_o = 3'b001 << (idx_r - 3'd3);
          end
          if (idx_r == 3'd5) begin
            state_nx_s = ST_WARM;
          end else begin
            state_nx_s = ST_LOAD;
          end
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_WARM: begin
        eng_ce_o = 1'b1;
        if (warm_cnt_r == 11'd0) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WARM;
        end
      end
      ST_IDLE: begin
        pt_rdy_o = 1'b1;
        keyed_o  = 1'b1;
        // A plaintext handshake takes priority over a simultaneous rekey request.
        if (pt_vld_i) begin
          state_nx_s = ST_RUN;
        end else if (rekey_i) begin
          state_nx_s = ST_CLR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        keyed_o   = 1'b1;
        eng_ce_o  = 1'b1;
        eng_dat_o = tx_bit_s;
        if (bit_cnt_r == 5'd31) begin
          state_nx_s = ST_HOLD;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_HOLD: begin
        keyed_o  = 1'b1;
        ct_vld_o = 1'b1;
        if (ct_rdy_i) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      default: begin
        eng_n_rst_o = 1'b0;
        state_nx_s  = ST_CLR;
      end
    endcase
  end

  // State, counters and the plaintext/ciphertext shift registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_CLR;
      idx_r      <= 3'd0;
      warm_cnt_r <= 11'd0;
      bit_cnt_r  <= 5'd0;
      pt_sr_r    <= 32'h0000_0000;
      ct_sr_r    <= 32'h0000_0000;
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        ST_CLR: begin
          idx_r <= 3'd0;
        end
        ST_LOAD: begin
          if (kiv_vld_i) begin
            if (idx_r == 3'd5) begin
              idx_r      <= 3'd0;
              warm_cnt_r <= WARM_LAST;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        ST_WARM: begin
          if (warm_cnt_r != 11'd0) begin
            warm_cnt_r <= warm_cnt_r - 11'd1;
          end
        end
        ST_IDLE: begin
          if (pt_vld_i) begin
            pt_sr_r   <= pt_dat_i;
            bit_cnt_r <= 5'd0;
          end
        end
        ST_RUN: begin
          bit_cnt_r <= bit_cnt_r + 5'd1;
`ifdef TRIVIUM_CTRL_MSB_FIRST_EN
          pt_sr_r <= {pt_sr_r[30:0], 1'b0};
          ct_sr_r <= {ct_sr_r[30:0], eng_dat_i};
`else
          pt_sr_r <= {1'b0, pt_sr_r[31:1]};
          ct_sr_r <= {eng_dat_i, ct_sr_r[31:1]};
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_ctrl.sv
// Directed bench for trivium_ctrl with a toy keystream engine (bit = hash of the engine's ce count).
// Honours TRIVIUM_CTRL_MSB_FIRST_EN for the expected bit order.
module tb_trivium_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        kiv_vld, kiv_rdy;
  logic [31:0] kiv_dat;
  logic        rekey;
  logic        pt_vld, pt_rdy;
  logic [31:0] pt_dat;
  logic        ct_vld, ct_rdy;
  logic [31:0] ct_dat;
  logic        keyed, eng_n_rst, eng_ce, eng_dat, eng_dat_in;
  logic [31:0] eng_ld_dat;
  logic [2:0]  eng_ld_a, eng_ld_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] eng_cnt;
  logic [31:0] base;
  logic [31:0] kw [6];
  logic [31:0] ct1, rec;

  always #5 clk = ~clk;

  trivium_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .kiv_vld_i(kiv_vld), .kiv_rdy_o(kiv_rdy), .kiv_dat_i(kiv_dat),
    .rekey_i(rekey),
    .pt_vld_i(pt_vld), .pt_rdy_o(pt_rdy), .pt_dat_i(pt_dat),
    .ct_vld_o(ct_vld), .ct_rdy_i(ct_rdy), .ct_dat_o(ct_dat),
    .keyed_o(keyed), .eng_n_rst_o(eng_n_rst), .eng_ce_o(eng_ce),
    .eng_ld_dat_o(eng_ld_dat), .eng_ld_a_o(eng_ld_a), .eng_ld_b_o(eng_ld_b),
    .eng_dat_o(eng_dat), .eng_dat_i(eng_dat_in)
  );

  function automatic logic ks(input logic [31:0] c);
    logic [31:0] h;
    h = c * 32'h9E37_79B9;
    return h[31] ^ h[17];
  endfunction

  // Toy engine: counts enabled cycles since its reset; output bit = input XOR keystream.
  always @(posedge clk) begin
    if (!eng_n_rst) eng_cnt <= 32'd0;
    else if (eng_ce) eng_cnt <= eng_cnt + 32'd1;
  end
  assign eng_dat_in = eng_dat ^ ks(eng_cnt);

  function automatic int pos(input int i);
`ifdef TRIVIUM_CTRL_MSB_FIRST_EN
    return 31 - i;
`else
    return i;
`endif
  endfunction

  function automatic logic [31:0] exp_ct(input logic [31:0] pt, input logic [31:0] c0);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) r[pos(i)] = pt[pos(i)] ^ ks(c0 + 32'(i));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 with the DUT in CLR.
  task automatic key_seq(input logic check_ready, input int stall_at);
    int n;
    @(negedge clk);
    chk("clr_nrst", 32'(eng_n_rst), 32'd0);
    chk("clr_keyed", 32'(keyed), 32'd0);
    chk("clr_ce", 32'(eng_ce), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      if (i == stall_at) begin
        kiv_vld = 1'b0;
        @(negedge clk);
        chk("stall_ce", 32'(eng_ce), 32'd0);
        chk("stall_rdy", 32'(kiv_rdy), 32'd1);
        chk("stall_strobe", 32'({eng_ld_a, eng_ld_b}), 32'd0);
        @(posedge clk); #1;
      end
      kiv_dat = kw[i];
      kiv_vld = 1'b1;
      @(negedge clk);
      chk("load_nrst", 32'(eng_n_rst), 32'd1);
      chk("load_rdy", 32'(kiv_rdy), 32'd1);
      chk("load_ce", 32'(eng_ce), 32'd1);
      chk("load_dat", eng_ld_dat, kw[i]);
      chk("load_a", 32'(eng_ld_a), (i < 3) ? (32'd1 << i) : 32'd0);
      chk("load_b", 32'(eng_ld_b), (i >= 3) ? (32'd1 << (i - 3)) : 32'd0);
      @(posedge clk); #1;
    end
    kiv_vld = 1'b0;
    kiv_dat = 32'd0;
    if (check_ready) begin
      n = 7;
      forever begin
        @(negedge clk);
        if (pt_rdy === 1'b1 || n > 2000) break;
        @(posedge clk); #1;
        n++;
      end
      chk("ready_latency", 32'(n), 32'd1159);
      chk("ce_total_key", eng_cnt, 32'd1158);
      chk("keyed_idle", 32'(keyed), 32'd1);
      @(posedge clk); #1;
      base = 32'd1158;
    end
  endtask

  // Entered at posedge+1 with the DUT in IDLE; leaves it in IDLE at posedge+1.
  task automatic run_word(input logic [31:0] pt, input int bp, output logic [31:0] ct);
    logic [31:0] exp;
    int bad;
    exp = exp_ct(pt, base);
    pt_dat = pt;
    pt_vld = 1'b1;
    @(negedge clk);
    chk("idle_pt_rdy", 32'(pt_rdy), 32'd1);
    @(posedge clk); #1;
    pt_vld = 1'b0;
    rekey  = 1'b0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (eng_ce !== 1'b1 || eng_dat !== pt[pos(i)] || pt_rdy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("run_bits", 32'(bad), 32'd0);
    @(negedge clk);
    chk("hold_vld", 32'(ct_vld), 32'd1);
    chk("hold_keyed", 32'(keyed), 32'd1);
    chk("ct_word", ct_dat, exp);
    ct = ct_dat;
    if (bp > 0) begin
      bad = 0;
      for (int i = 0; i < bp; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (ct_vld !== 1'b1 || ct_dat !== exp || eng_ce !== 1'b0 || pt_rdy !== 1'b0) bad++;
      end
      chk("hold_stable", 32'(bad), 32'd0);
    end
    ct_rdy = 1'b1;
    @(posedge clk); #1;
    ct_rdy = 1'b0;
    base = base + 32'd32;
  endtask

  initial begin
    rst = 1'b1; kiv_vld = 1'b0; kiv_dat = 32'd0; rekey = 1'b0;
    pt_vld = 1'b0; pt_dat = 32'd0; ct_rdy = 1'b0; base = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_nrst", 32'(eng_n_rst), 32'd0);
    chk("rst_keyed", 32'(keyed), 32'd0);
    chk("rst_ct_dat", ct_dat, 32'd0);
    chk("rst_outs", 32'({kiv_rdy, pt_rdy, ct_vld, eng_ce, eng_dat, eng_ld_a, eng_ld_b}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First keying with a load stall, then reset in the middle of warm-up.
    kw[0] = 32'h1111_1111; kw[1] = 32'h2222_2222; kw[2] = 32'h0000_3333;
    kw[3] = 32'h4444_4444; kw[4] = 32'h5555_5555; kw[5] = 32'h0000_6666;
    key_seq(1'b0, 3);
    repeat (100) @(posedge clk);
    #1;
    @(negedge clk);
    chk("warm_ce", 32'(eng_ce), 32'd1);
    chk("warm_dat", 32'(eng_dat), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_ce", 32'(eng_ce), 32'd0);
    chk("rst_mid_nrst", 32'(eng_n_rst), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero key/IV; keystream words with one backpressured word.
    for (int i = 0; i < 6; i++) kw[i] = 32'd0;
    key_seq(1'b1, -1);
    run_word(32'h0000_0000, 0, ct1);
    run_word(32'h0000_0000, 50, ct1);
    run_word(32'h0000_0000, 0, ct1);
    run_word(32'h0000_0000, 0, ct1);
    chk("ce_total_words", eng_cnt, 32'd1286);

    // Rekey together with a pt handshake: the word wins.
    rekey = 1'b1;
    run_word(32'h1234_5678, 0, ct1);
    run_word(32'h0000_0001, 0, ct1);
    rekey = 1'b1;
    @(posedge clk); #1;
    rekey = 1'b0;

    // Round trip: encrypt, rekey with the same key/IV, decrypt.
    kw[0] = 32'h8000_0000;
    key_seq(1'b1, -1);
    run_word(32'hDEAD_BEEF, 0, ct1);
    rekey = 1'b1;
    @(posedge clk); #1;
    rekey = 1'b0;
    key_seq(1'b1, -1);
    run_word(ct1, 0, rec);
    chk("round_trip", rec, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
